// File: rtl/dram_cmd_sched.sv
// Single-bank DRAM command scheduler with an open-page policy.
// Accepts read/write requests, keeps the last activated row open and
// services refresh. It issues ACT/RD/WR/PRE/REF only when the matching
// timing-done levels from the timing controller allow it.
module dram_cmd_sched #(
    parameter int ROW_W = 14,
    parameter int COL_W = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    output logic             req_ready,
    input  logic             tACT_done,
    input  logic             tWR_done,
    input  logic             tRD_done,
    input  logic             tPRE_done,
    input  logic             tREF_done,
    input  logic             tWRITE_done,
    input  logic             tWTR_done,
    input  logic             tRAS_done,
    input  logic             rf_req,
    output logic             cmd_valid,
    output logic [2:0]       cmd,
    output logic [ROW_W-1:0] cmd_row,
    output logic [COL_W-1:0] cmd_col,
    output logic             row_open,
    output logic             busy
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ACT_ISSUE = 4'd1,
        ACT_WAIT  = 4'd2,
        RW_ISSUE  = 4'd3,
        RW_WAIT   = 4'd4,
        PRE_ISSUE = 4'd5,
        PRE_WAIT  = 4'd6,
        REF_ISSUE = 4'd7,
        REF_WAIT  = 4'd8
    } stateT;

    stateT            stateR;
    stateT            nextStateS;

    // Set for exactly the first cycle of every WAIT state, so stale done
    // levels left over from the previous command are not acted upon.
    logic             waitEntryR;
    logic             refPendR;
    logic             rowOpenR;
    logic [ROW_W-1:0] openRowR;

    // Request captured when IDLE commits to serving it.
    logic             lwR;
    logic [ROW_W-1:0] lrowR;
    logic [COL_W-1:0] lcolR;

    logic             cmdValidR;
    logic [2:0]       cmdR;
    logic [ROW_W-1:0] cmdRowR;
    logic [COL_W-1:0] cmdColR;
    logic             reqReadyR;
    logic             busyR;

    logic [2:0]       issueCmdS;
    logic             latchReqS;
    logic             setRefPendS;
    logic             rowHitS;
    logic             rwGateS;
    logic             rwDoneS;

    // Next-state decision and the command (if any) issued this cycle.
    always_comb begin
        nextStateS  = stateR;
        issueCmdS   = CMD_NOP;
        latchReqS   = 1'b0;
        setRefPendS = 1'b0;
        rowHitS     = rowOpenR && (req_row == openRowR);
        rwGateS     = lwR ? (tACT_done && tRD_done) : (tACT_done && tWTR_done);
        rwDoneS     = lwR ? tWRITE_done : tRD_done;
        case (stateR)
            IDLE: begin
                if (rf_req) begin
                    if (rowOpenR) begin
                        nextStateS  = PRE_ISSUE;
                        setRefPendS = 1'b1;
                    end else begin
                        nextStateS  = REF_ISSUE;
                    end
                end else if (req_valid) begin
                    latchReqS = 1'b1;
                    if (rowHitS) begin
                        nextStateS = RW_ISSUE;
                    end else if (rowOpenR) begin
                        nextStateS = PRE_ISSUE;
                    end else begin
                        nextStateS = ACT_ISSUE;
                    end
                end else begin
                    nextStateS = IDLE;
                end
            end
            ACT_ISSUE: begin
                if (tPRE_done && tREF_done) begin
                    issueCmdS  = CMD_ACT;
                    nextStateS = ACT_WAIT;
                end else begin
                    nextStateS = ACT_ISSUE;
                end
            end
            ACT_WAIT: begin
                if (!waitEntryR && tACT_done) begin
                    nextStateS = RW_ISSUE;
                end else begin
                    nextStateS = ACT_WAIT;
                end
            end
            RW_ISSUE: begin
                if (rwGateS) begin
                    issueCmdS  = lwR ? CMD_WR : CMD_RD;
                    nextStateS = RW_WAIT;
                end else begin
                    nextStateS = RW_ISSUE;
                end
            end
            RW_WAIT: begin
                if (!waitEntryR && rwDoneS) begin
                    nextStateS = IDLE;
                end else begin
                    nextStateS = RW_WAIT;
                end
            end
            PRE_ISSUE: begin
                if (tRAS_done && tWR_done && tRD_done) begin
                    issueCmdS  = CMD_PRE;
                    nextStateS = PRE_WAIT;
                end else begin
                    nextStateS = PRE_ISSUE;
                end
            end
            PRE_WAIT: begin
                if (!waitEntryR && tPRE_done) begin
                    nextStateS = refPendR ? REF_ISSUE : ACT_ISSUE;
                end else begin
                    nextStateS = PRE_WAIT;
                end
            end
            REF_ISSUE: begin
                if (tPRE_done) begin
                    issueCmdS  = CMD_REF;
                    nextStateS = REF_WAIT;
                end else begin
                    nextStateS = REF_ISSUE;
                end
            end
            REF_WAIT: begin
                if (!waitEntryR && tREF_done) begin
                    nextStateS = IDLE;
                end else begin
                    nextStateS = REF_WAIT;
                end
            end
            default: begin
                nextStateS = IDLE;
            end
        endcase
    end

    // FSM state register plus the WAIT-entry marker.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateR     <= IDLE;
            waitEntryR <= 1'b0;
        end else begin
            stateR     <= nextStateS;
            waitEntryR <= (issueCmdS != CMD_NOP);
        end
    end

    // Bank bookkeeping: open row tracking, pending refresh, latched request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rowOpenR <= 1'b0;
            openRowR <= {ROW_W{1'b0}};
            refPendR <= 1'b0;
            lwR      <= 1'b0;
            lrowR    <= {ROW_W{1'b0}};
            lcolR    <= {COL_W{1'b0}};
        end else begin
            if (issueCmdS == CMD_ACT) begin
                rowOpenR <= 1'b1;
                openRowR <= lrowR;
            end else if (issueCmdS == CMD_PRE) begin
                rowOpenR <= 1'b0;
            end
            if (setRefPendS) begin
                refPendR <= 1'b1;
            end else if (issueCmdS == CMD_REF) begin
                refPendR <= 1'b0;
            end
            if (latchReqS) begin
                lwR   <= req_write;
                lrowR <= req_row;
                lcolR <= req_col;
            end
        end
    end

    // Registered command bus: one-cycle strobes, address fields hold when idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmdValidR <= 1'b0;
            cmdR      <= CMD_NOP;
            cmdRowR   <= {ROW_W{1'b0}};
            cmdColR   <= {COL_W{1'b0}};
            reqReadyR <= 1'b0;
            busyR     <= 1'b0;
        end else begin
            cmdValidR <= (issueCmdS != CMD_NOP);
            cmdR      <= issueCmdS;
            reqReadyR <= (issueCmdS == CMD_RD) || (issueCmdS == CMD_WR);
            busyR     <= (nextStateS != IDLE);
            if (issueCmdS == CMD_ACT) begin
                cmdRowR <= lrowR;
            end
            if ((issueCmdS == CMD_RD) || (issueCmdS == CMD_WR)) begin
                cmdColR <= lcolR;
            end
        end
    end

    assign cmd_valid = cmdValidR;
    assign cmd       = cmdR;
    assign cmd_row   = cmdRowR;
    assign cmd_col   = cmdColR;
    assign req_ready = reqReadyR;
    assign row_open  = rowOpenR;
    assign busy      = busyR;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Testbench for dram_cmd_sched: directed scenarios plus a randomized
// request stream checked against a command-order reference model.
module tb_dram_cmd_sched;
    localparam int ROW_W = 14;
    localparam int COL_W = 10;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0;
    logic [ROW_W-1:0] req_row = '0;
    logic [COL_W-1:0] req_col = '0;
    logic req_ready;
    logic tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done, tWRITE_done, tWTR_done, tRAS_done;
    logic rf_req = 1'b0;
    logic cmd_valid;
    logic [2:0] cmd;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic row_open, busy;

    int vecs = 0;
    int errs = 0;

    dram_cmd_sched #(.ROW_W(ROW_W), .COL_W(COL_W)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_write(req_write), .req_row(req_row), .req_col(req_col),
        .req_ready(req_ready),
        .tACT_done(tACT_done), .tWR_done(tWR_done), .tRD_done(tRD_done), .tPRE_done(tPRE_done),
        .tREF_done(tREF_done), .tWRITE_done(tWRITE_done), .tWTR_done(tWTR_done), .tRAS_done(tRAS_done),
        .rf_req(rf_req),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .row_open(row_open), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic setDones(input logic v);
        {tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done, tWRITE_done, tWTR_done, tRAS_done} = {8{v}};
    endtask

    task automatic applyReq(input logic w, input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        req_valid = 1'b1; req_write = w; req_row = r; req_col = c;
    endtask

    task automatic nextStrobe(input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (cmd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitIdle(input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Gate a command must have seen (done vector order: ACT WR RD PRE REF WRITE WTR RAS).
    function automatic logic gateOk(input logic [2:0] c, input logic [7:0] d);
        case (c)
            ACT:     return d[4] & d[3];
            RD:      return d[7] & d[1];
            WR:      return d[7] & d[5];
            PRE:     return d[0] & d[6] & d[5];
            REF:     return d[4];
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        RST = 1'b1; setDones(1'b1);
        repeat (2) step();
        vecs++;
        if ({cmd_valid, cmd, cmd_row, cmd_col, req_ready, busy, row_open} !== {1'b1 ^ 1'b1, NOP, 14'h0, 10'h0, 3'b000}) begin
            errs++; $display("FAIL reset_values got v=%b c=%0d r=%h col=%h rdy=%b busy=%b open=%b want all zero",
                cmd_valid, cmd, cmd_row, cmd_col, req_ready, busy, row_open);
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_closed_read();
        logic ok;
        applyReq(1'b0, 14'h12, 10'h5);
        step();
        vecs++;
        if ({busy, cmd_valid} !== 2'b10) begin
            errs++; $display("FAIL closed_c1 got busy=%b v=%b want 1 0", busy, cmd_valid);
        end
        step();
        vecs++;
        if ({cmd_valid, cmd, cmd_row, row_open} !== {1'b1, ACT, 14'h12, 1'b1}) begin
            errs++; $display("FAIL closed_act got v=%b c=%0d r=%h open=%b want 1 1 12 1", cmd_valid, cmd, cmd_row, row_open);
        end
        step();
        vecs++;
        if ({cmd_valid, cmd, cmd_row} !== {1'b0, NOP, 14'h12}) begin
            errs++; $display("FAIL closed_hold got v=%b c=%0d r=%h want 0 0 12", cmd_valid, cmd, cmd_row);
        end
        step(); step();
        vecs++;
        if ({cmd_valid, cmd, cmd_col, req_ready} !== {1'b1, RD, 10'h5, 1'b1}) begin
            errs++; $display("FAIL closed_rd got v=%b c=%0d col=%h rdy=%b want 1 2 5 1", cmd_valid, cmd, cmd_col, req_ready);
        end
        req_valid = 1'b0;
        step(); step();
        vecs++;
        if ({busy, row_open, req_ready} !== 3'b010) begin
            errs++; $display("FAIL closed_done got busy=%b open=%b rdy=%b want 0 1 0", busy, row_open, req_ready);
        end
        ok = 1'b1;
    endtask

    task automatic test_row_hit();
        logic ok;
        applyReq(1'b0, 14'h12, 10'h9);
        step();
        vecs++;
        if (cmd_valid !== 1'b0) begin
            errs++; $display("FAIL hit_early got v=%b c=%0d want 0", cmd_valid, cmd);
        end
        step();
        vecs++;
        if ({cmd_valid, cmd, cmd_col, req_ready} !== {1'b1, RD, 10'h9, 1'b1}) begin
            errs++; $display("FAIL hit_rd got v=%b c=%0d col=%h rdy=%b want 1 2 9 1", cmd_valid, cmd, cmd_col, req_ready);
        end
        req_valid = 1'b0;
        waitIdle(20, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL hit_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_row_miss();
        logic ok;
        tRAS_done = 1'b0;
        applyReq(1'b1, 14'h40, 10'h3);
        for (int i = 0; i < 5; i++) begin
            step();
            vecs++;
            if (cmd_valid !== 1'b0) begin
                errs++; $display("FAIL miss_stall got v=%b c=%0d want 0", cmd_valid, cmd);
            end
        end
        tRAS_done = 1'b1;
        step();
        vecs++;
        if ({cmd_valid, cmd, row_open} !== {1'b1, PRE, 1'b0}) begin
            errs++; $display("FAIL miss_pre got v=%b c=%0d open=%b want 1 4 0", cmd_valid, cmd, row_open);
        end
        nextStrobe(30, ok);
        vecs++;
        if ({ok, cmd, cmd_row, row_open} !== {1'b1, ACT, 14'h40, 1'b1}) begin
            errs++; $display("FAIL miss_act got ok=%b c=%0d r=%h open=%b want 1 1 40 1", ok, cmd, cmd_row, row_open);
        end
        nextStrobe(30, ok);
        vecs++;
        if ({ok, cmd, cmd_col, req_ready} !== {1'b1, WR, 10'h3, 1'b1}) begin
            errs++; $display("FAIL miss_wr got ok=%b c=%0d col=%h rdy=%b want 1 3 3 1", ok, cmd, cmd_col, req_ready);
        end
        req_valid = 1'b0;
        waitIdle(20, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL miss_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        applyReq(1'b1, 14'h40, 10'h11);
        step(); step();
        vecs++;
        if ({cmd_valid, cmd, cmd_col, req_ready} !== {1'b1, WR, 10'h11, 1'b1}) begin
            errs++; $display("FAIL b2b_wr got v=%b c=%0d col=%h rdy=%b want 1 3 11 1", cmd_valid, cmd, cmd_col, req_ready);
        end
        req_valid = 1'b0;
        waitIdle(20, ok);
        tWTR_done = 1'b0;
        applyReq(1'b0, 14'h40, 10'h22);
        for (int i = 0; i < 4; i++) begin
            step();
            vecs++;
            if (cmd_valid !== 1'b0) begin
                errs++; $display("FAIL wtr_early got v=%b c=%0d want 0", cmd_valid, cmd);
            end
        end
        tWTR_done = 1'b1;
        step();
        vecs++;
        if ({cmd_valid, cmd, cmd_col, req_ready} !== {1'b1, RD, 10'h22, 1'b1}) begin
            errs++; $display("FAIL wtr_rd got v=%b c=%0d col=%h rdy=%b want 1 2 22 1", cmd_valid, cmd, cmd_col, req_ready);
        end
        req_valid = 1'b0;
        waitIdle(20, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL wtr_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_refresh();
        logic ok;
        rf_req = 1'b1;
        applyReq(1'b0, 14'h40, 10'h33);
        nextStrobe(20, ok);
        vecs++;
        if ({ok, cmd, row_open, req_ready} !== {1'b1, PRE, 1'b0, 1'b0}) begin
            errs++; $display("FAIL ref_pre got ok=%b c=%0d open=%b rdy=%b want 1 4 0 0", ok, cmd, row_open, req_ready);
        end
        tPRE_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++;
            if (cmd_valid !== 1'b0) begin
                errs++; $display("FAIL ref_stall got v=%b c=%0d want 0", cmd_valid, cmd);
            end
        end
        tPRE_done = 1'b1;
        nextStrobe(20, ok);
        vecs++;
        if ({ok, cmd, req_ready} !== {1'b1, REF, 1'b0}) begin
            errs++; $display("FAIL ref_ref got ok=%b c=%0d rdy=%b want 1 5 0", ok, cmd, req_ready);
        end
        rf_req = 1'b0;
        nextStrobe(30, ok);
        vecs++;
        if ({ok, cmd, cmd_row} !== {1'b1, ACT, 14'h40}) begin
            errs++; $display("FAIL ref_act got ok=%b c=%0d r=%h want 1 1 40", ok, cmd, cmd_row);
        end
        nextStrobe(30, ok);
        vecs++;
        if ({ok, cmd, cmd_col, req_ready} !== {1'b1, RD, 10'h33, 1'b1}) begin
            errs++; $display("FAIL ref_rd got ok=%b c=%0d col=%h rdy=%b want 1 2 33 1", ok, cmd, cmd_col, req_ready);
        end
        req_valid = 1'b0;
        waitIdle(20, ok);
    endtask

    task automatic test_async_reset();
        logic ok;
        applyReq(1'b0, 14'h77, 10'h1);
        nextStrobe(20, ok);
        nextStrobe(20, ok);
        vecs++;
        if ({ok, cmd, cmd_row} !== {1'b1, ACT, 14'h77}) begin
            errs++; $display("FAIL rst_setup_act got ok=%b c=%0d r=%h want 1 1 77", ok, cmd, cmd_row);
        end
        tACT_done = 1'b0;
        step();
        #2 RST = 1'b1;
        #1;
        vecs++;
        if ({cmd_valid, cmd, cmd_row, cmd_col, req_ready, busy, row_open} !== {1'b0, NOP, 14'h0, 10'h0, 3'b000}) begin
            errs++; $display("FAIL rst_async got v=%b c=%0d r=%h col=%h rdy=%b busy=%b open=%b want all zero",
                cmd_valid, cmd, cmd_row, cmd_col, req_ready, busy, row_open);
        end
        req_valid = 1'b0;
        tACT_done = 1'b1;
        step(); step();
        RST = 1'b0;
        step();
        applyReq(1'b0, 14'h77, 10'h1);
        step(); step();
        vecs++;
        if ({cmd_valid, cmd, cmd_row} !== {1'b1, ACT, 14'h77}) begin
            errs++; $display("FAIL rst_reopen got v=%b c=%0d r=%h want 1 1 77", cmd_valid, cmd, cmd_row);
        end
        nextStrobe(20, ok);
        vecs++;
        if ({ok, cmd, req_ready} !== {1'b1, RD, 1'b1}) begin
            errs++; $display("FAIL rst_rd got ok=%b c=%0d rdy=%b want 1 2 1", ok, cmd, req_ready);
        end
        req_valid = 1'b0;
        waitIdle(20, ok);
    endtask

    // Random requests and random timing levels; the model predicts the
    // command order from the open-page rules only.
    task automatic test_random();
        logic [2:0]       qCmd[$];
        logic [15:0]      qAddr[$];
        logic             mOpen = 1'b1;
        logic [ROW_W-1:0] mRow = 14'h77;
        logic [7:0]       prevD;
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
        logic             w;
        logic [2:0]       ec;
        logic [15:0]      ea;
        int               issued = 0;
        int               served = 0;
        int               gap = 0;
        int               cyc = 0;
        prevD = 8'hFF;
        while (served < 40 && cyc < 20000) begin
            if (cmd_valid === 1'b1) begin
                vecs++;
                if (qCmd.size() == 0) begin
                    errs++; $display("FAIL rnd_unexpected got c=%0d want none", cmd);
                end else begin
                    ec = qCmd.pop_front();
                    ea = qAddr.pop_front();
                    if (cmd !== ec || (ec == ACT && 16'(cmd_row) !== ea) || ((ec == RD || ec == WR) && 16'(cmd_col) !== ea)
                        || !gateOk(cmd, prevD) || row_open !== (ec != PRE) || req_ready !== (ec == RD || ec == WR)) begin
                        errs++; $display("FAIL rnd_cmd got c=%0d r=%h col=%h rdy=%b open=%b dones=%b want c=%0d addr=%h",
                            cmd, cmd_row, cmd_col, req_ready, row_open, prevD, ec, ea);
                    end
                end
                if (cmd == RD || cmd == WR) begin
                    served++;
                    req_valid = 1'b0;
                    gap = $urandom_range(0, 2);
                end
            end else begin
                vecs++;
                if (req_ready !== 1'b0) begin
                    errs++; $display("FAIL rnd_ready got rdy=%b with no strobe want 0", req_ready);
                end
            end
            if (!req_valid && gap == 0 && issued < 40) begin
                r = ($urandom_range(0, 4) == 0) ? ROW_W'($urandom) : ROW_W'($urandom_range(0, 2));
                c = COL_W'($urandom);
                w = 1'($urandom);
                if (!(mOpen && r == mRow)) begin
                    if (mOpen) begin qCmd.push_back(PRE); qAddr.push_back(16'h0); end
                    qCmd.push_back(ACT); qAddr.push_back(16'(r));
                end
                qCmd.push_back(w ? WR : RD); qAddr.push_back(16'(c));
                mOpen = 1'b1; mRow = r;
                applyReq(w, r, c);
                issued++;
            end else if (gap > 0) begin
                gap--;
            end
            {tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done, tWRITE_done, tWTR_done, tRAS_done} =
                {8{1'b1}} & {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            prevD = {tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done, tWRITE_done, tWTR_done, tRAS_done};
            step();
            cyc++;
        end
        vecs++;
        if (served != 40 || qCmd.size() != 0) begin
            errs++; $display("FAIL rnd_complete got served=%0d left=%0d want 40 0", served, qCmd.size());
        end
        setDones(1'b1);
        req_valid = 1'b0;
    endtask

    initial begin
        setDones(1'b1);
        test_reset();
        test_closed_read();
        test_row_hit();
        test_row_miss();
        test_back_to_back();
        test_refresh();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dram_cmd_sched.md
# dram_cmd_sched

Single-bank DRAM command scheduler for the memory controller. It accepts read/write requests, tracks the open row under an open-page policy, and services refresh. It issues ACT/RD/WR/PRE/REF commands, gating each one on the `t*_done` and `rf_req` levels from the timing controller. The timing controller restarts its counters on each `cmd_valid` pulse.

## Interface
- `ROW_W`, default 14: row address width.
- `COL_W`, default 10: column address width.

Ports:
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request pending; held with fields stable until `req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_row` in ROW_W: target row.
- `req_col` in COL_W: target column.
- `req_ready` out 1: one-cycle pulse; the request was consumed (RD/WR issued).
- `tACT_done`, `tWR_done`, `tRD_done`, `tPRE_done`, `tREF_done`, `tWRITE_done`, `tWTR_done`, `tRAS_done` in 1 each: timing-satisfied levels.
- `rf_req` in 1: refresh required (level).
- `cmd_valid` out 1: one-cycle command strobe.
- `cmd` out 3: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF.
- `cmd_row` out ROW_W: row for ACT.
- `cmd_col` out COL_W: column for RD/WR.
- `row_open` out 1: a row is currently open.
- `busy` out 1: state != IDLE.

## Operation
- States:
  - IDLE
  - ACT_ISSUE, ACT_WAIT
  - RW_ISSUE, RW_WAIT
  - PRE_ISSUE, PRE_WAIT
  - REF_ISSUE, REF_WAIT
- Internal registers:
  - `open_row` (ROW_W)
  - `ref_pend` (1 bit)
  - latched request: `lw`, `lrow`, `lcol`, captured on leaving IDLE for a request.
- IDLE priority (refresh wins over requests):
  - `rf_req` & `row_open` -> PRE_ISSUE, set `ref_pend`.
  - `rf_req` & !`row_open` -> REF_ISSUE.
  - `req_valid` & `row_open` & `req_row`==`open_row` (hit) -> RW_ISSUE.
  - `req_valid` & `row_open` & miss -> PRE_ISSUE.
  - `req_valid` & !`row_open` -> ACT_ISSUE.
- ACT_ISSUE:
  - Gate: `tPRE_done` & `tREF_done`.
  - On gate: issue ACT with `cmd_row`=`lrow`; set `row_open`=1, `open_row`=`lrow`; go to ACT_WAIT.
- ACT_WAIT: wait `tACT_done` -> RW_ISSUE.
- RW_ISSUE:
  - Read gate: `tACT_done` & `tWTR_done`.
  - Write gate: `tACT_done` & `tRD_done`.
  - On gate: issue RD/WR with `cmd_col`=`lcol`, pulse `req_ready`, go to RW_WAIT.
- RW_WAIT: read waits `tRD_done`; write waits `tWRITE_done`; then IDLE.
- PRE_ISSUE:
  - Gate: `tRAS_done` & `tWR_done` & `tRD_done`.
  - On gate: issue PRE, clear `row_open`, go to PRE_WAIT.
- PRE_WAIT: wait `tPRE_done`; then REF_ISSUE if `ref_pend`, else ACT_ISSUE (latched request still pending).
- REF_ISSUE: gate `tPRE_done`; issue REF, clear `ref_pend`, go to REF_WAIT.
- REF_WAIT: wait `tREF_done` -> IDLE.
- `rf_req` is only acted on in IDLE. An access in progress always completes, and the request is not dropped.
- Issue-state gates are evaluated every cycle; the FSM stalls indefinitely while a gate is low.

## Timing
- All outputs are registered.
- Issuing a command means that in the cycle after the issue condition is met:
  - `cmd_valid`=1 with `cmd`, `cmd_row` and `cmd_col` valid;
  - `req_ready`=1 for RD/WR.
- Both strobes last exactly one cycle. This is the first cycle of the WAIT state.
- When `cmd_valid`=0: `cmd`=NOP, and `cmd_row`/`cmd_col` hold their last values.
- WAIT states ignore done inputs in their entry cycle; the earliest exit is 2 cycles after `cmd_valid`. Stale done levels are therefore tolerated.
- Latency with all gates high:
  - Hit read: decision at cycle 0, RD at cycle 2, IDLE at cycle 4.
  - Closed-bank read: ACT at cycle 2, RD at cycle 5.
  - Miss: PRE at cycle 2, ACT at cycle 5, RD at cycle 8.
- `row_open` changes in the same cycle as the ACT/PRE strobe.
- Reset values:
  - state IDLE; `row_open`=0, `open_row`=0, `ref_pend`=0.
  - `cmd_valid`=0, `cmd`=NOP, `cmd_row`=0, `cmd_col`=0.
  - `req_ready`=0, `busy`=0.
- Reset mid-operation aborts immediately to these values. No PRE is issued; the bank is treated as closed, and reinitialisation is the caller's responsibility.
- Row compare is full ROW_W equality. `open_row` is meaningful only while `row_open`=1.

## Test plan
- Reset, then closed-bank read of row 0x12, col 0x5 with all dones high -> ACT row 0x12 at cycle 2, RD col 0x5 + `req_ready` at cycle 5, `row_open`=1, `busy`=0 at cycle 7.
- Row hit: second read of row 0x12, col 0x9 -> no ACT; RD col 0x9 two cycles after `req_valid`.
- Row miss: write to row 0x40 while 0x12 is open, `tRAS_done` held low 5 cycles -> PRE delayed until `tRAS_done` rises; then PRE, ACT 0x40, WR in order; `open_row`=0x40.
- Refresh with an open row: `rf_req`=1 and `req_valid`=1 together in IDLE -> PRE, then REF (after `tPRE_done`); back to IDLE on `tREF_done`, then the request is served with ACT.
- Write-to-read turnaround: write hit, then read hit with `tWTR_done` low 4 cycles -> RD strobe occurs the cycle after `tWTR_done` rises, never earlier.
- Asynchronous `RST` asserted in ACT_WAIT -> all outputs at reset values immediately; after release, the next request issues ACT (not RD).
